bl_order_decode: RTL and testbench

- Receive-side counterpart of bl_order_gen in the X-engine.
- Consumes the generator's per-cycle baseline stream (ant_a, ant_b, buf_sel, qualified by en).
- Converts each pair to a linear baseline index for vector-accumulator addressing.
- Checks the stream against the canonical order, flagging any deviation, and marks frame boundaries.

---
 rtl/xeng_bl_pkg.sv | 31 +++
 rtl/bl_tri_counter.sv | 58 +++++
 rtl/bl_order_decode.sv | 125 ++++++++++++
 tb/tb_bl_order_decode.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xeng_bl_pkg.sv
// Shared X-engine baseline-order definitions: width helpers, the baseline
// count function and the canonical order constants used by bl_order_gen and
// bl_order_decode.
package xeng_bl_pkg;

    // Ceiling log2; log2(1) = 0.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Baselines per frame including autocorrelations.
    function automatic int n_bls(input int n);
        return n * (n + 1) / 2;
    endfunction

    // Canonical order: outer loop a = 0..N-1, inner loop b = 0..a.
    // Frame 0 after sync uses buffer 0; the buffer flips at every frame wrap.
    localparam logic BL_FIRST_BUF      = 1'b0;
    localparam logic BL_BUF_WRAP_FLIP  = 1'b1;

    typedef enum logic {
        BL_IDLE = 1'b0,
        BL_RUN  = 1'b1
    } bl_dec_state_t;

endpackage

// File: rtl/bl_tri_counter.sv
// Triangular (a, b) counter walking the canonical baseline order.
// idx = a*(a+1)/2 + b is produced without a multiplier: base holds the
// row offset and is bumped by a+1 at the end of each row.
module bl_tri_counter
    import xeng_bl_pkg::*;
#(
    parameter int N_ANTS   = 8,
    parameter int ANT_BITS = log2(N_ANTS),
    parameter int BL_BITS  = log2(n_bls(N_ANTS))
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                adv,
    output logic [ANT_BITS-1:0] exp_a,
    output logic [ANT_BITS-1:0] exp_b,
    output logic [BL_BITS-1:0]  idx,
    output logic                wrap
);

    logic [BL_BITS-1:0] base;
    logic               row_end;
    logic               last_row;

    // Row/frame end detection and current linear index.
    always_comb begin
        row_end  = (exp_b == exp_a);
        last_row = (exp_a == ANT_BITS'(N_ANTS - 1));
        wrap     = adv && row_end && last_row;
        idx      = base + BL_BITS'(exp_b);
    end

    // Counter advance; clr restarts the order at baseline 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_a <= '0;
            exp_b <= '0;
            base  <= '0;
        end else if (clr) begin
            exp_a <= '0;
            exp_b <= '0;
            base  <= '0;
        end else if (adv) begin
            if (wrap) begin
                exp_a <= '0;
                exp_b <= '0;
                base  <= '0;
            end else if (row_end) begin
                exp_b <= '0;
                exp_a <= exp_a + 1'b1;
                base  <= base + BL_BITS'(exp_a) + BL_BITS'(1);
            end else begin
                exp_b <= exp_b + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bl_order_decode.sv
// Baseline order decoder: turns the generator's (ant_a, ant_b, buf_sel)
// stream into linear baseline indices, checks it against the canonical order
// and marks frame ends. Optional mismatch counter: BL_ORDER_DECODE_ERR_CNT_EN.
//
// state | meaning
// IDLE  | waiting for the first sync; en ignored
// RUN   | decoding and checking every en sample
module bl_order_decode
    import xeng_bl_pkg::*;
#(
    parameter int N_ANTS   = 8,
    parameter int ANT_BITS = log2(N_ANTS),
    parameter int N_BLS    = n_bls(N_ANTS),
    parameter int BL_BITS  = log2(N_BLS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync,
    input  logic                en,
    input  logic [ANT_BITS-1:0] ant_a,
    input  logic [ANT_BITS-1:0] ant_b,
    input  logic                buf_sel,
    output logic [BL_BITS-1:0]  bl_idx,
    output logic                bl_valid,
    output logic                bl_buf,
    output logic                frame_done,
    output logic                order_err
`ifdef BL_ORDER_DECODE_ERR_CNT_EN
    ,
    output logic [15:0]         err_cnt
`endif
);

    bl_dec_state_t      state, state_nxt;
    logic               clr;
    logic               accept;
    logic               mismatch;
    logic               exp_buf;
    logic [ANT_BITS-1:0] exp_a, exp_b;
    logic [BL_BITS-1:0] idx;
    logic               wrap;

    bl_tri_counter #(
        .N_ANTS   (N_ANTS),
        .ANT_BITS (ANT_BITS),
        .BL_BITS  (BL_BITS)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .adv   (accept),
        .exp_a (exp_a),
        .exp_b (exp_b),
        .idx   (idx),
        .wrap  (wrap)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BL_IDLE;
        else        state <= state_nxt;
    end

    // Next state; sync beats en so a sample coinciding with sync is dropped.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        accept    = 1'b0;
        case (state)
            BL_IDLE: begin
                if (sync) begin
                    state_nxt = BL_RUN;
                    clr       = 1'b1;
                end
            end
            BL_RUN: begin
                if (sync)    clr    = 1'b1;
                else if (en) accept = 1'b1;
            end
            default: state_nxt = BL_IDLE;
        endcase
    end

    // Order check against the expected counters and buffer.
    always_comb begin
        mismatch = (ant_a != exp_a) || (ant_b != exp_b) || (buf_sel != exp_buf);
    end

    // Output registers; the index comes from the counters so it stays
    // monotone even when the input stream is wrong.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bl_idx     <= '0;
            bl_valid   <= 1'b0;
            bl_buf     <= 1'b0;
            frame_done <= 1'b0;
            order_err  <= 1'b0;
            exp_buf    <= BL_FIRST_BUF;
        end else begin
            bl_valid   <= accept;
            frame_done <= wrap;
            if (accept) begin
                bl_idx <= idx;
                bl_buf <= buf_sel;
            end
            if (clr) begin
                order_err <= 1'b0;
                exp_buf   <= BL_FIRST_BUF;
            end else if (accept) begin
                if (mismatch) order_err <= 1'b1;
                if (wrap)     exp_buf   <= exp_buf ^ BL_BUF_WRAP_FLIP;
            end
        end
    end

`ifdef BL_ORDER_DECODE_ERR_CNT_EN
    // Saturating count of mismatching samples since the last sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  err_cnt <= '0;
        else if (clr)                                err_cnt <= '0;
        else if (accept && mismatch && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_bl_order_decode.sv
// Scoreboard bench for bl_order_decode (N_ANTS = 8): stimulus pushes the
// expected response, a negedge monitor pops and compares on bl_valid.
module tb_bl_order_decode;

    localparam int N_ANTS   = 8;
    localparam int ANT_BITS = 3;
    localparam int N_BLS    = 36;
    localparam int BL_BITS  = 6;

    logic                clk;
    logic                rst_n;
    logic                sync;
    logic                en;
    logic [ANT_BITS-1:0] ant_a;
    logic [ANT_BITS-1:0] ant_b;
    logic                buf_sel;
    logic [BL_BITS-1:0]  bl_idx;
    logic                bl_valid;
    logic                bl_buf;
    logic                frame_done;
    logic                order_err;
`ifdef BL_ORDER_DECODE_ERR_CNT_EN
    logic [15:0]         err_cnt;
`endif

    bl_order_decode #(.N_ANTS(N_ANTS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync       (sync),
        .en         (en),
        .ant_a      (ant_a),
        .ant_b      (ant_b),
        .buf_sel    (buf_sel),
        .bl_idx     (bl_idx),
        .bl_valid   (bl_valid),
        .bl_buf     (bl_buf),
        .frame_done (frame_done),
        .order_err  (order_err)
`ifdef BL_ORDER_DECODE_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   idx;
        logic bufv;
        logic fd;
        logic err;
        int   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic err_m  = 1'b0;
    int   cnt_m  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        else             n_pass++;
    endtask

    // Monitor: every valid output must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bl_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(bl_idx), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("bl_idx",     32'(bl_idx),     32'(e.idx));
                    chk("bl_buf",     32'(bl_buf),     32'(e.bufv));
                    chk("frame_done", 32'(frame_done), 32'(e.fd));
                    chk("order_err",  32'(order_err),  32'(e.err));
`ifdef BL_ORDER_DECODE_ERR_CNT_EN
                    chk("err_cnt",    32'(err_cnt),    32'(e.cnt));
`endif
                end
            end else begin
                chk("frame_done_idle", 32'(frame_done), 32'd0);
            end
        end
    end

    task automatic send(input int a, input int b, input logic bs, input int idx, input bit mis);
        exp_t e;
        ant_a   = ANT_BITS'(a);
        ant_b   = ANT_BITS'(b);
        buf_sel = bs;
        en      = 1'b1;
        sync    = 1'b0;
        if (mis) begin
            err_m = 1'b1;
            cnt_m++;
        end
        e.idx  = idx;
        e.bufv = bs;
        e.fd   = (idx == N_BLS - 1);
        e.err  = err_m;
        e.cnt  = cnt_m;
        exp_q.push_back(e);
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_sync();
        sync = 1'b1;
        en   = 1'b0;
        @(negedge clk);
        sync  = 1'b0;
        err_m = 1'b0;
        cnt_m = 0;
    endtask

    // sync together with a sample: the sample must vanish and errors clear.
    task automatic sync_with_en(input int a, input int b, input logic bs);
        ant_a   = ANT_BITS'(a);
        ant_b   = ANT_BITS'(b);
        buf_sel = bs;
        sync    = 1'b1;
        en      = 1'b1;
        @(negedge clk);
        sync  = 1'b0;
        en    = 1'b0;
        err_m = 1'b0;
        cnt_m = 0;
        chk("sync_en_valid", 32'(bl_valid),   32'd0);
        chk("sync_en_done",  32'(frame_done), 32'd0);
        chk("sync_err_clr",  32'(order_err),  32'd0);
    endtask

    // Canonical frame; stops before stop_idx, optionally corrupts ant_b at
    // inject_idx and optionally leaves a one-cycle gap after each sample.
    task automatic gen_frame(input logic drv_buf, input logic exp_buf, input int inject_idx,
                             input bit gap, input int stop_idx);
        int  idx;
        int  bb;
        bit  mis;
        for (int a = 0; a < N_ANTS; a++) begin
            for (int b = 0; b <= a; b++) begin
                idx = a * (a + 1) / 2 + b;
                if (idx >= stop_idx) return;
                bb  = (idx == inject_idx) ? b + 1 : b;
                mis = (drv_buf != exp_buf) || (idx == inject_idx);
                send(a, bb, drv_buf, idx, mis);
                if (gap) idle(1);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        sync    = 1'b0;
        en      = 1'b0;
        ant_a   = '0;
        ant_b   = '0;
        buf_sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bl_valid",  32'(bl_valid),   32'd0);
        chk("rst_bl_idx",    32'(bl_idx),     32'd0);
        chk("rst_order_err", 32'(order_err),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // IDLE ignores en until the first sync.
        send_ignored(3);
        chk("idle_no_valid", 32'(bl_valid), 32'd0);

        // Two continuous frames, buffers 0 then 1.
        do_sync();
        gen_frame(1'b0, 1'b0, -1, 1'b0, N_BLS);
        gen_frame(1'b1, 1'b1, -1, 1'b0, N_BLS);
        idle(2);
        chk("clean_err", 32'(order_err), 32'd0);

        // Same order with en toggling.
        do_sync();
        gen_frame(1'b0, 1'b0, -1, 1'b1, N_BLS);
        idle(2);

        // ant_b corrupted at index 5.
        do_sync();
        gen_frame(1'b0, 1'b0, 5, 1'b0, N_BLS);
        idle(2);
        chk("inject_sticky", 32'(order_err), 32'd1);

        // buf_sel not toggled at the wrap.
        do_sync();
        gen_frame(1'b0, 1'b0, -1, 1'b0, N_BLS);
        gen_frame(1'b0, 1'b1, -1, 1'b0, 4);
        idle(2);

        // Error set, then sync with en at index 20 (a=5, b=5).
        do_sync();
        gen_frame(1'b0, 1'b0, 3, 1'b0, 20);
        idle(1);
        chk("pre_sync_err", 32'(order_err), 32'd1);
        sync_with_en(5, 5, 1'b0);
        gen_frame(1'b0, 1'b0, -1, 1'b0, N_BLS);

        // sync on the last baseline: no frame_done.
        gen_frame(1'b1, 1'b1, -1, 1'b0, N_BLS - 1);
        sync_with_en(7, 7, 1'b1);
        gen_frame(1'b0, 1'b0, -1, 1'b0, 3);

        // Async reset mid-frame while an output is valid.
        ant_a   = 3'd2;
        ant_b   = 3'd0;
        buf_sel = 1'b0;
        en      = 1'b1;
        @(posedge clk);
        #2;
        en = 1'b0;
        chk("pre_rst_valid", 32'(bl_valid), 32'd1);
        chk("pre_rst_idx",   32'(bl_idx),   32'd3);
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bl_valid), 32'd0);
        chk("async_idx",   32'(bl_idx),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_ignored(4);
        chk("post_rst_idle", 32'(bl_valid), 32'd0);
        do_sync();
        gen_frame(1'b0, 1'b0, -1, 1'b0, N_BLS);
        idle(3);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // en samples that must not produce output (no expectation pushed).
    task automatic send_ignored(input int n);
        for (int i = 0; i < n; i++) begin
            ant_a   = '0;
            ant_b   = '0;
            buf_sel = 1'b0;
            en      = 1'b1;
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
    endtask

endmodule
